// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU slice.
//   - opcode encodings OP_ADD..OP_MUL (13-15 reserved)
//   - flag bit positions inside the 4-bit NZCV vector
//   - controller state encoding
//   - mk_flags(): packs individual N/Z/C/V bits into the flag vector
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_ORR = 4'd5;
   localparam logic [3:0] OP_EOR = 4'd6;
   localparam logic [3:0] OP_MOV = 4'd7;
   localparam logic [3:0] OP_MVN = 4'd8;
   localparam logic [3:0] OP_LSL = 4'd9;
   localparam logic [3:0] OP_LSR = 4'd10;
   localparam logic [3:0] OP_ASR = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [3:0] mk_flags(input logic n, input logic z,
                                           input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per cycle.
//   clk, rst_n  clock / async active-low reset
//   load_i      captures a_i, b_i, clears accumulator and step counter, starts run
//   a_i, b_i    operands
//   product_o   accumulator value after the current step (final when last_o=1)
//   last_o      high in the cycle whose step is the final one
module alu_mul_iter #(
   parameter int WIDTH = 32,
   parameter int STEPS = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] product_o,
   output logic             last_o
);

   localparam int CW = $clog2(STEPS);

   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
   logic [CW-1:0]    cnt_q;
   logic             run_q;

   // Partial product for step i is a << i when b[i] is set; the sum is kept
   // at WIDTH bits, so the result is the low half of the product.
   always_comb begin
      acc_d = acc_q;
      if (b_q[cnt_q]) acc_d = acc_q + (a_q << cnt_q);
   end

   assign product_o = acc_d;
   assign last_o    = run_q && (cnt_q == CW'(STEPS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (load_i) begin
         a_q   <= a_i;
         b_q   <= b_i;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         acc_q <= acc_d;
         if (cnt_q == CW'(STEPS - 1)) run_q <= 1'b0;
         else                         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU producing a registered result and NZCV flags.
//   clk, rst_n         clock / async active-low reset
//   start_i            request, sampled only when idle
//   op_i, a_i, b_i     opcode and operands (b_i[4:0] is the shift amount)
//   set_flags_i        1: flags from result, 0: pass captured inflags through
//   inflags_i          current NZCV from the flags register
//   busy_o             high while not idle
//   done_o             one-cycle strobe, result/outflags valid from this cycle
//   result_o           registered result, held until the next done
//   outflags_o         registered NZCV, held until the next done
module alu_seq_core
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MUL_STEPS = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             set_flags_i,
   input  logic [3:0]       inflags_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [3:0]       outflags_o
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sf_q, mul_ld_q;
   logic [3:0]       inf_q;

   logic [WIDTH-1:0] b_op, alu_res, mul_prod;
   logic [WIDTH:0]   sum, sh_l, sh_r, sh_ra;
   logic [SHW-1:0]   sh;
   logic             cin, c_new, v_new, rsvd, mul_last;
   logic [3:0]       alu_flags;

   // Shifts run one bit wider so the last bit shifted out lands in the
   // extra position (top for LSL, bottom for LSR/ASR).
   assign sh    = b_i[SHW-1:0];
   assign sh_l  = {1'b0, a_i} << sh;
   assign sh_r  = {a_i, 1'b0} >> sh;
   assign sh_ra = $signed({a_i, 1'b0}) >>> sh;

   always_comb begin
      b_op    = b_i;
      cin     = 1'b0;
      sum     = '0;
      alu_res = '0;
      c_new   = inflags_i[FLAG_C];
      v_new   = inflags_i[FLAG_V];
      rsvd    = 1'b0;
      case (op_i)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            // Subtract as a + ~b + carry-in, so C comes out as NOT borrow.
            if (op_i == OP_SUB || op_i == OP_SBC) b_op = ~b_i;
            if (op_i == OP_SUB)                        cin = 1'b1;
            else if (op_i == OP_ADC || op_i == OP_SBC) cin = inflags_i[FLAG_C];
            sum     = {1'b0, a_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
            alu_res = sum[WIDTH-1:0];
            c_new   = sum[WIDTH];
            v_new   = (a_i[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_AND: alu_res = a_i & b_i;
         OP_ORR: alu_res = a_i | b_i;
         OP_EOR: alu_res = a_i ^ b_i;
         OP_MOV: alu_res = b_i;
         OP_MVN: alu_res = ~b_i;
         OP_LSL: begin
            alu_res = sh_l[WIDTH-1:0];
            if (sh != '0) c_new = sh_l[WIDTH];
         end
         OP_LSR: begin
            alu_res = sh_r[WIDTH:1];
            if (sh != '0) c_new = sh_r[0];
         end
         OP_ASR: begin
            alu_res = sh_ra[WIDTH:1];
            if (sh != '0) c_new = sh_ra[0];
         end
         default: rsvd = 1'b1;
      endcase
      if (rsvd || !set_flags_i) alu_flags = inflags_i;
      else alu_flags = mk_flags(alu_res[WIDTH-1], alu_res == '0, c_new, v_new);
   end

   // Multiplier loads from the captured operands one cycle after the start
   // edge, then runs MUL_STEPS steps; done lands after edge MUL_STEPS+1.
   alu_mul_iter #(.WIDTH(WIDTH), .STEPS(MUL_STEPS)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (mul_ld_q),
      .a_i       (a_q),
      .b_i       (b_q),
      .product_o (mul_prod),
      .last_o    (mul_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         done_o     <= 1'b0;
         result_o   <= '0;
         outflags_o <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sf_q       <= 1'b0;
         inf_q      <= '0;
         mul_ld_q   <= 1'b0;
      end else begin
         done_o   <= 1'b0;
         mul_ld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  a_q   <= a_i;
                  b_q   <= b_i;
                  sf_q  <= set_flags_i;
                  inf_q <= inflags_i;
                  if (op_i == OP_MUL) begin
                     mul_ld_q <= 1'b1;
                     state_q  <= ST_MUL;
                  end else begin
                     result_o   <= alu_res;
                     outflags_o <= alu_flags;
                     done_o     <= 1'b1;
                     state_q    <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               if (mul_last) begin
                  result_o   <= mul_prod;
                  outflags_o <= sf_q ? mk_flags(mul_prod[WIDTH-1], mul_prod == '0,
                                                inf_q[FLAG_C], inf_q[FLAG_V])
                                     : inf_q;
                  done_o     <= 1'b1;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [3:0]  op_i = '0;
   logic [31:0] a_i = '0, b_i = '0;
   logic        set_flags_i = 1'b0;
   logic [3:0]  inflags_i = '0;
   logic        busy_o, done_o;
   logic [31:0] result_o;
   logic [3:0]  outflags_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_seq_core dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .op_i        (op_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .set_flags_i (set_flags_i),
      .inflags_i   (inflags_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .result_o    (result_o),
      .outflags_o  (outflags_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issues one op; lat = edges after the start edge until done is seen,
   // bc = cycles with busy high before done.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sf, input logic [3:0] inf);
      @(negedge clk);
      op_i = op; a_i = a; b_i = b; set_flags_i = sf; inflags_i = inf; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sf, input logic [3:0] inf,
                         input logic [31:0] exp_res, input logic [3:0] exp_fl,
                         input int exp_lat);
      int lat, bc;
      issue(op, a, b, sf, inf);
      // Scramble inputs: captured values must be the ones used.
      a_i = ~a; b_i = ~b; inflags_i = ~inf; set_flags_i = ~sf;
      lat = 0; bc = 0;
      while (!done_o && lat < 100) begin
         if (busy_o) bc++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, result_o, exp_res);
      chk({tag, "_fl"}, {28'd0, outflags_o}, {28'd0, exp_fl});
      if (exp_lat > 0) chk({tag, "_busy"}, bc, exp_lat);
      @(posedge clk); #1;
      chk({tag, "_done1"}, {31'd0, done_o}, 32'd0);
   endtask

   initial begin
      int nd, done_at;
      logic [31:0] res_seen;

      #12;
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_res", result_o, 32'd0);
      chk("rst_fl", {28'd0, outflags_o}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 4'b0000, 32'h8000_0000, 4'b1001, 0);
      repeat (3) @(posedge clk); #1;
      chk("hold_res", result_o, 32'h8000_0000);
      run_op("sub_eq", OP_SUB, 32'd5, 32'd5, 1'b1, 4'b0000, 32'd0, 4'b0110, 0);
      run_op("sub_nf", OP_SUB, 32'd5, 32'd5, 1'b0, 4'b1010, 32'd0, 4'b1010, 0);
      run_op("sub_brw", OP_SUB, 32'd0, 32'd1, 1'b1, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 0);
      run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 1'b1, 4'b0000, 32'h7FFF_FFFF, 4'b0011, 0);
      run_op("adc", OP_ADC, 32'hFFFF_FFFF, 32'd0, 1'b1, 4'b0010, 32'd0, 4'b0110, 0);
      run_op("sbc", OP_SBC, 32'd5, 32'd3, 1'b1, 4'b0000, 32'd1, 4'b0010, 0);
      run_op("and", OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 4'b0011, 32'h0000_00F0, 4'b0011, 0);
      run_op("mvn", OP_MVN, 32'h1234_5678, 32'd0, 1'b1, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 0);
      run_op("lsr", OP_LSR, 32'h3, 32'd1, 1'b1, 4'b0000, 32'h1, 4'b0010, 0);
      run_op("lsl0", OP_LSL, 32'h1, 32'd0, 1'b1, 4'b0010, 32'h1, 4'b0010, 0);
      run_op("lsl1", OP_LSL, 32'h8000_0001, 32'd1, 1'b1, 4'b0000, 32'h2, 4'b0010, 0);
      run_op("asr", OP_ASR, 32'h8000_0000, 32'd4, 1'b1, 4'b0001, 32'hF800_0000, 4'b1001, 0);
      run_op("rsvd", 4'd13, 32'h55, 32'h66, 1'b1, 4'b0101, 32'd0, 4'b0101, 0);
      run_op("mul_big", OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 4'b1011, 32'd0, 4'b0111, 33);
      run_op("mul_76", OP_MUL, 32'd7, 32'd6, 1'b1, 4'b0000, 32'd42, 4'b0000, 33);

      // Start held during MUL and its DONE cycle with another op: ignored.
      issue(OP_MUL, 32'd9, 32'd5, 1'b1, 4'b1010);
      nd = 0; done_at = -1; res_seen = '0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         start_i = (k >= 3 && k <= 34);
         op_i = OP_ADD; a_i = 32'd1; b_i = 32'd1; set_flags_i = 1'b0; inflags_i = 4'b0000;
         @(posedge clk); #1;
         if (done_o) begin
            nd++;
            if (done_at < 0) begin
               done_at  = k;
               res_seen = result_o;
            end
         end
      end
      start_i = 1'b0;
      chk("ign_ndone", nd, 1);
      chk("ign_at", done_at, 33);
      chk("ign_res", res_seen, 32'd45);
      chk("ign_fl", {28'd0, outflags_o}, {28'd0, 4'b0010});

      // Reset at MUL step 10 aborts with immediate clear.
      issue(OP_MUL, 32'd7, 32'd6, 1'b1, 4'b1111);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy_o}, 32'd0);
      chk("arst_done", {31'd0, done_o}, 32'd0);
      chk("arst_res", result_o, 32'd0);
      chk("arst_fl", {28'd0, outflags_o}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done_o || busy_o) nd++;
      end
      chk("arst_nodone", nd, 0);
      run_op("add_post", OP_ADD, 32'd2, 32'd3, 1'b1, 4'b0000, 32'd5, 4'b0000, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Sequential 32-bit ALU; sits directly upstream of the flags register.
- Accepts one operation per start pulse and returns a registered result plus NZCV flags with a done strobe.
- Its outflags feed the flags register; the flags register's currentflags return as inflags.
- Single-cycle ops complete in 1 cycle; MUL runs an iterative 32-step shift-add.

Parameters:
- WIDTH, 32, datapath width.
- MUL_STEPS, WIDTH, multiplier iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  opcode, captured at accepted start.
- a  in  WIDTH  operand A, captured at accepted start.
- b  in  WIDTH  operand B, captured at accepted start; b[4:0] is the shift amount.
- set_flags  in  1  1 = update flags from the result; 0 = pass inflags through.
- inflags  in  4  current flags [3]=N [2]=Z [1]=C [0]=V, captured at accepted start.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse; result and outflags are valid from this cycle.
- result  out  WIDTH  registered result; holds until the next done.
- outflags  out  4  registered flags, same bit order; hold until the next done.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, result=0, outflags=0, multiplier counter and accumulator cleared.
- Reset mid-MUL aborts the operation; no done is produced.
- State IDLE: start=1 captures op, a, b, set_flags and inflags.
  - op=MUL: go to MUL.
  - Any other op: compute at this edge and go to DONE.
  - start=0: stay in IDLE.
- State MUL: one shift-add step per cycle for 32 cycles; counter runs 0..31. At count 31, load result and go to DONE.
- State DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored while busy, including in the DONE cycle.
- Latency, counting the start edge as edge 0:
  - Single-cycle ops: done is high in the cycle after edge 0.
  - MUL: done is high after edge 33.
- Opcodes:
  - 0 ADD, 1 ADC (adds C), 2 SUB (a-b), 3 SBC (a-b-!C).
  - 4 AND, 5 ORR, 6 EOR, 7 MOV (result=b), 8 MVN (~b).
  - 9 LSL, 10 LSR, 11 ASR.
  - 12 MUL (low 32 bits of the unsigned product).
  - 13-15 reserved.
- Arithmetic flags:
  - Use a 33-bit sum; C = bit 32.
  - Subtract is a + ~b + 1 (or + C for SBC), so C = NOT borrow.
  - V = signed overflow: operand signs equal and result sign differs, using ~b for subtract.
- Flag rules, applied when set_flags=1:
  - N=result[31], Z=(result==0) for all ops.
  - Logic ops and MOV/MVN: C and V preserved from captured inflags.
  - Shifts: C = last bit shifted out; amount 0 keeps C; V preserved.
  - ASR fills with a[31]. Amounts 1..31 only, since the shift amount is b[4:0].
  - MUL: N and Z updated; C and V preserved.
- set_flags=0: outflags = captured inflags at done; result still updates.
- Reserved opcodes: result=0, outflags=captured inflags regardless of set_flags, done still pulses.
- Operand or input changes after the start edge have no effect.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_MUL.
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - state encoding IDLE/MUL/DONE.
- One sub-module, alu_mul_iter: shift-add multiplier.
  - Inputs: load, a, b.
  - Each step adds a<<i to the accumulator when b[i]=1.
  - Outputs the product after 32 steps.
- Flag and arithmetic logic stays in alu_seq_core.

Test Plan:
- ADD a=0x7FFFFFFF b=0x00000001 set_flags=1 -> done after 1 cycle; result=0x80000000; outflags=4'b1001 (N, V).
- SUB a=5 b=5 set_flags=1 -> result=0; outflags=4'b0110 (Z, C=no borrow). Same op with set_flags=0, inflags=4'b1010 -> outflags=4'b1010.
- LSR a=0x00000003 b=1, inflags=0 -> result=0x00000001, outflags=4'b0010. LSL a=1 b=0, inflags C=1 -> result=1, C stays 1.
- MUL a=0x00010000 b=0x00010000 -> busy for 33 cycles; done after edge 33; result=0; outflags Z=1, C/V equal to inflags. MUL 7*6 -> 42.
- Start pulsed again during MUL with a different op -> ignored; only one done, carrying the MUL result.
- rst_n low at MUL step 10 -> busy=0, done=0, result=0, outflags=0 immediately (async). A new ADD 2+3 after release -> result=5.
